// File: rtl/fifo_pkg.sv
// Shared sizing defaults and helpers for the dual-port-RAM streaming FIFO.
package fifo_pkg;
  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_ADDR_W = 6;
  localparam int FIFO_DEPTH  = 2 ** FIFO_ADDR_W;

  // Level must reach DEPTH + 2 (full RAM plus full skid); one spare bit keeps it at ADDR_W+2.
  function automatic int level_w(input int addr_w);
    return $clog2((2 ** addr_w) + 3) + 1;
  endfunction
endpackage

// File: rtl/dpram_skid2.sv
// Two-entry output skid: captures RAM read data, presents the head show-ahead.
module dpram_skid2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              cap,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              pop,
  output logic [1:0]        cnt
);
  logic [1:0][DATA_W-1:0] skid;

  assign out_valid = (cnt != 2'd0);
  assign out_data  = skid[0];
  assign pop       = out_valid & out_ready;

  // The issue logic upstream guarantees a capture never lands on a full skid without a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid <= '0;
      cnt  <= 2'd0;
    end else if (flush) begin
      skid <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({pop, cap})
        2'b11: begin
          if (cnt == 2'd1) begin
            skid[0] <= cap_data;
          end else begin
            skid[0] <= skid[1];
            skid[1] <= cap_data;
          end
        end
        2'b10: begin
          skid[0] <= skid[1];
          cnt     <= cnt - 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd0) skid[0] <= cap_data;
          else             skid[1] <= cap_data;
          cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/dpram_stream_fifo.sv
// Valid/ready FIFO controller over an external true dual-port RAM; port A writes, port B prefetches.
module dpram_stream_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [level_w(ADDR_W)-1:0]  level,
  output logic [ADDR_W-1:0]           ram_addr_a,
  output logic [DATA_W-1:0]           ram_data_a,
  output logic                        ram_we_a,
  output logic [ADDR_W-1:0]           ram_addr_b,
  output logic                        ram_we_b,
  input  logic [DATA_W-1:0]           ram_q_b
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LW    = level_w(ADDR_W);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              rd_pend;
  logic [1:0]        skid_cnt;
  logic              push, pop, rd_issue;

  assign in_ready = (ram_cnt != (ADDR_W+1)'(DEPTH));
  assign push     = in_valid & in_ready;
  // Issue only if the word will find a free skid slot when it returns next cycle.
  assign rd_issue = (ram_cnt != '0) &&
                    (({1'b0, skid_cnt} + {2'b0, rd_pend}) < (3'd2 + {2'b0, pop}));

  assign ram_addr_a = wr_ptr;
  assign ram_data_a = in_data;
  assign ram_we_a   = push;
  assign ram_addr_b = rd_ptr;
  assign ram_we_b   = 1'b0;

  assign level = LW'(ram_cnt) + LW'(rd_pend) + LW'(skid_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      rd_pend <= rd_issue;
      case ({push, rd_issue})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  dpram_skid2 #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .cap       (rd_pend),
    .cap_data  (ram_q_b),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .pop       (pop),
    .cnt       (skid_cnt)
  );
endmodule

// File: tb/tb_dpram_stream_fifo.sv
// Bench for dpram_stream_fifo with a 64x8 dual-port RAM model and an in-order scoreboard.
module tb_dpram_stream_fifo;
  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data, ram_data_a, ram_q_b;
  logic [7:0] level;
  logic [5:0] ram_addr_a, ram_addr_b;
  logic       ram_we_a, ram_we_b;

  logic [7:0] mem [64];
  logic [7:0] q[$];
  int n_cmp = 0, n_err = 0, n_push = 0;
  int cnt;

  always #5 clk = ~clk;

  dpram_stream_fifo dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
    .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a), .ram_we_a(ram_we_a),
    .ram_addr_b(ram_addr_b), .ram_we_b(ram_we_b), .ram_q_b(ram_q_b)
  );

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    ram_q_b <= mem[ram_addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: handshakes are sampled mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("pop_on_empty_sb", 32'(out_data), 32'hFFFF_FFFF);
        else               chk("stream_data", 32'(out_data), 32'(q.pop_front()));
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        n_push++;
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    repeat (3) tick;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_we_b", 32'(ram_we_b), 32'd0);
    rst_n = 1'b1;

    // Reset asserted mid-burst must clear outputs without waiting for a clock edge
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin in_data = 8'(8'h10 + i); tick; end
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_level", 32'(level), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    q.delete(); n_push = 0;
    tick;
    rst_n = 1'b1;
    tick;
    chk("post_rst_no_valid", 32'(out_valid), 32'd0);

    // First push after reset: visible after two edges
    in_valid = 1'b1; in_data = 8'hA5;
    tick;
    in_valid = 1'b0;
    chk("lat_edge0_valid", 32'(out_valid), 32'd0);
    chk("lat_edge0_level", 32'(level), 32'd1);
    tick;
    chk("lat_edge1_valid", 32'(out_valid), 32'd0);
    tick;
    chk("lat_edge2_valid", 32'(out_valid), 32'd1);
    chk("lat_edge2_data", 32'(out_data), 32'hA5);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("lat_drained_level", 32'(level), 32'd0);

    // Fill with consumer stalled
    cnt = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!in_ready) break;
      in_data = 8'(cnt);
      tick;
      cnt++;
    end
    in_valid = 1'b0;
    tick;
    chk("fill_push_count", 32'(cnt), 32'd66);
    chk("fill_level", 32'(level), 32'd66);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_hold_data", 32'(out_data), 32'd0);

    // Drain: one word per cycle, no bubbles
    cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!out_valid) break;
      tick;
      cnt++;
    end
    out_ready = 1'b0;
    chk("drain_count", 32'(cnt), 32'd66);
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Push+pop with one word in RAM and a full skid
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin in_data = 8'(8'hC0 + i); tick; end
    in_valid = 1'b0;
    repeat (3) tick;
    chk("rc1_level_pre", 32'(level), 32'd3);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(8'hD0 + i);
      tick;
      chk("rc1_level_const", 32'(level), 32'd3);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && level != 0; i++) tick;
    out_ready = 1'b0;
    chk("rc1_empty", 32'(level), 32'd0);

    // Full, then simultaneous push+pop: level settles at DEPTH+1 and stays
    in_valid = 1'b1;
    for (int i = 0; i < 100 && in_ready; i++) begin in_data = 8'(8'h80 + i); tick; end
    chk("full2_level", 32'(level), 32'd66);
    out_ready = 1'b1;
    in_data = 8'hEE;
    tick;
    chk("full_pp_first", 32'(level), 32'd65);
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'hF0 + i);
      tick;
      chk("full_pp_const", 32'(level), 32'd65);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 100 && level != 0; i++) tick;
    out_ready = 1'b0;
    chk("full_pp_drained", 32'(level), 32'd0);

    // Random streaming across pointer wrap
    cnt = 0;
    for (int i = 0; i < 3000 && cnt < 200; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      if (in_valid && in_ready) cnt++;
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 300 && (q.size() != 0 || level != 0); i++) tick;
    out_ready = 1'b0;
    chk("rand_pushed", 32'(cnt), 32'd200);
    chk("rand_sb_empty", 32'(q.size()), 32'd0);
    chk("rand_level", 32'(level), 32'd0);
    chk("rand_wr_ptr", 32'(ram_addr_a), 32'(n_push % 64));
    chk("rand_rd_ptr", 32'(ram_addr_b), 32'(n_push % 64));

    // Flush while a read is in flight and the skid is occupied
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin in_data = 8'(8'h30 + i); tick; end
    in_valid = 1'b0;
    repeat (3) tick;
    out_ready = 1'b1;
    tick;
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    q.delete();
    tick;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_push = 0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 8'h5A;
    tick;
    in_valid = 1'b0;
    repeat (2) tick;
    chk("post_flush_valid", 32'(out_valid), 32'd1);
    chk("post_flush_data", 32'(out_data), 32'h5A);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("post_flush_sb", 32'(q.size()), 32'd0);
    chk("post_flush_level", 32'(level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
